// File: rtl/clint_lite.sv
// Lightweight core-local interruptor: 64-bit mtime/mtimecmp timer plus msip software interrupt,
// exposed through a 64 KiB word-addressed register window with a valid/ready request/response bus.
module clint_lite #(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        irq_timer_o,
    output logic        irq_software_o
);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;
    localparam logic [15:0] PRE_LAST     = 16'(TICK_DIV - 1);

    logic [15:0] pre;
    logic        tick;
    logic [63:0] mtime, mtime_nxt;
    logic [63:0] mtimecmp, cmp_nxt;
    logic        msip, msip_nxt;

    logic [15:0] offset;
    logic        in_win, mapped;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mtime_lo, sel_mtime_hi;
    logic [31:0] rd_val;
    logic        xfer, wr;

    assign tick = (pre == PRE_LAST);

    // Byte lane bits are masked so every access targets a whole word.
    always_comb begin
        offset       = req_addr_i[15:0] & 16'hFFFC;
        in_win       = (req_addr_i[31:16] == BASE_ADDR[31:16]);
        sel_msip     = in_win && (offset == OFF_MSIP);
        sel_cmp_lo   = in_win && (offset == OFF_CMP_LO);
        sel_cmp_hi   = in_win && (offset == OFF_CMP_HI);
        sel_mtime_lo = in_win && (offset == OFF_MTIME_LO);
        sel_mtime_hi = in_win && (offset == OFF_MTIME_HI);
        mapped       = sel_msip || sel_cmp_lo || sel_cmp_hi || sel_mtime_lo || sel_mtime_hi;
        rd_val       = '0;
        if (sel_msip)     rd_val = {31'b0, msip};
        if (sel_cmp_lo)   rd_val = mtimecmp[31:0];
        if (sel_cmp_hi)   rd_val = mtimecmp[63:32];
        if (sel_mtime_lo) rd_val = mtime[31:0];
        if (sel_mtime_hi) rd_val = mtime[63:32];
    end

    assign req_ready_o    = rst_i || !rsp_valid_o || rsp_ready_i;
    assign xfer           = req_valid_i && req_ready_o && !rst_i;
    assign wr             = xfer && req_we_i;
    assign irq_software_o = msip;

    // A write to either mtime half overrides that cycle's increment; the other half is left untouched.
    always_comb begin
        mtime_nxt = mtime + {63'b0, tick};
        if (wr && sel_mtime_lo) mtime_nxt = {mtime[63:32], req_wdata_i};
        if (wr && sel_mtime_hi) mtime_nxt = {req_wdata_i, mtime[31:0]};
        cmp_nxt = mtimecmp;
        if (wr && sel_cmp_lo) cmp_nxt[31:0]  = req_wdata_i;
        if (wr && sel_cmp_hi) cmp_nxt[63:32] = req_wdata_i;
        msip_nxt = msip;
        if (wr && sel_msip) msip_nxt = req_wdata_i[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre         <= '0;
            mtime       <= '0;
            mtimecmp    <= '1;
            msip        <= 1'b0;
            irq_timer_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            pre         <= tick ? '0 : pre + 16'd1;
            mtime       <= mtime_nxt;
            mtimecmp    <= cmp_nxt;
            msip        <= msip_nxt;
            irq_timer_o <= (mtime_nxt >= cmp_nxt);
            if (xfer) begin
                rsp_valid_o <= 1'b1;
                rsp_rdata_o <= req_we_i ? '0 : rd_val;
                rsp_err_o   <= !mapped;
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clint_lite.sv
// Randomised bench: two instances (TICK_DIV 1 and 4) share one request stream and are each
// compared every cycle against a register-map model driven by cycle counts since reset.
module tb_clint_lite;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic        irq_timer [2];
    logic        irq_sw    [2];
    logic [31:0] rsp_rdata [2];

    clint_lite #(.TICK_DIV(1), .BASE_ADDR(32'h0200_0000)) dut_div1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[0]),
        .rsp_err_o(rsp_err[0]), .irq_timer_o(irq_timer[0]), .irq_software_o(irq_sw[0])
    );

    clint_lite #(.TICK_DIV(4), .BASE_ADDR(32'h0200_0000)) dut_div4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[1]),
        .rsp_err_o(rsp_err[1]), .irq_timer_o(irq_timer[1]), .irq_software_o(irq_sw[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural register contents plus expected registered outputs.
    int unsigned div [2];
    int unsigned m_cyc [2];
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    logic        e_valid, e_err;
    logic [31:0] e_rdata [2];
    logic        e_irq_t [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i]   = 0;
            m_time[i]  = 64'd0;
            m_cmp[i]   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip[i]  = 1'b0;
            e_rdata[i] = 32'd0;
            e_irq_t[i] = 1'b0;
        end
        e_valid = 1'b0;
        e_err   = 1'b0;
    endtask

    task automatic model_step();
        logic        xfer, mapped, tick;
        logic [15:0] off;
        logic [31:0] rv;
        logic [63:0] t;
        xfer   = req_valid && (!e_valid || rsp_ready);
        off    = req_addr[15:0] & 16'hFFFC;
        mapped = (req_addr[31:16] == 16'h0200) &&
                 (off == 16'h0000 || off == 16'h4000 || off == 16'h4004 ||
                  off == 16'hBFF8 || off == 16'hBFFC);
        for (int i = 0; i < 2; i++) begin
            tick = ((m_cyc[i] % div[i]) == div[i] - 1);
            m_cyc[i]++;
            rv = 32'd0;
            if (mapped) begin
                case (off)
                    16'h0000: rv = {31'd0, m_msip[i]};
                    16'h4000: rv = m_cmp[i][31:0];
                    16'h4004: rv = m_cmp[i][63:32];
                    16'hBFF8: rv = m_time[i][31:0];
                    default:  rv = m_time[i][63:32];
                endcase
            end
            t = m_time[i] + (tick ? 64'd1 : 64'd0);
            if (xfer && req_we && mapped) begin
                case (off)
                    16'h0000: m_msip[i] = req_wdata[0];
                    16'h4000: m_cmp[i][31:0]  = req_wdata;
                    16'h4004: m_cmp[i][63:32] = req_wdata;
                    16'hBFF8: t = {m_time[i][63:32], req_wdata};
                    default:  t = {req_wdata, m_time[i][31:0]};
                endcase
            end
            m_time[i]  = t;
            e_irq_t[i] = (m_time[i] >= m_cmp[i]);
            if (xfer) e_rdata[i] = (!req_we && mapped) ? rv : 32'd0;
        end
        if (xfer) begin
            e_valid = 1'b1;
            e_err   = !mapped;
        end else if (rsp_ready) begin
            e_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'hFFFF_FFF0;
            3:       return 32'd1;
            4:       return $urandom();
            default: return $urandom_range(0, 300);
        endcase
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [15:0] off;
        case ($urandom_range(0, 9))
            0, 1:    off = 16'h0000;
            2:       off = 16'h4000;
            3:       off = 16'h4004;
            4, 5:    off = 16'hBFF8;
            6:       off = 16'hBFFC;
            7:       off = 16'h0100;
            default: off = 16'($urandom());
        endcase
        off[1:0] = 2'($urandom());
        if ($urandom_range(0, 9) == 0) return {16'h0300, off};
        return {16'h0200, off};
    endfunction

    initial begin
        div[0]    = 1;
        div[1]    = 4;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        model_reset();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(e_valid));
                check($sformatf("rsp_err[%0d]", i),   64'(rsp_err[i]),   64'(e_err));
                check($sformatf("rsp_rdata[%0d]", i), 64'(rsp_rdata[i]), 64'(e_rdata[i]));
                check($sformatf("irq_timer[%0d]", i), 64'(irq_timer[i]), 64'(e_irq_t[i]));
                check($sformatf("irq_sw[%0d]", i),    64'(irq_sw[i]),    64'(m_msip[i]));
            end

            rst       = (cyc < 3) || ($urandom_range(0, 249) == 0);
            req_valid = ($urandom_range(0, 9) < 6);
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = pick_addr();
            req_wdata = pick_data();
            // Occasional long stalls exercise response hold-off and back-pressure.
            rsp_ready = ((cyc / 50) % 4 == 3) ? 1'b0 : ($urandom_range(0, 9) < 7);

            #1;
            for (int i = 0; i < 2; i++)
                check($sformatf("req_ready[%0d]", i), 64'(req_ready[i]),
                      64'(rst || !e_valid || rsp_ready));

            if (rst) model_reset();
            else     model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
